// File: rtl/noc_pkg.sv
// Shared encodings for the network-interface link controller: flit types and FSM states.
package noc_pkg;

   // Flit type lives in the two MSBs; 2'b00 and 2'b01 are both body flits.
   localparam logic [1:0] FT_HEAD = 2'b11;
   localparam logic [1:0] FT_TAIL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_SEND     = 2'd3
   } link_state_e;

endpackage

// File: rtl/ni_link_ctrl_if.sv
// Handshake bundle between the link controller (master) and its TX FIFO (slave).
interface ni_link_ctrl_if #(
   parameter int FLIT_W = 32
);
   logic              push;
   logic              pop;
   logic [FLIT_W-1:0] wdata;
   logic [FLIT_W-1:0] rdata;
   logic              full;
   logic              empty;

   modport master (output push, pop, wdata, input rdata, full, empty);
   modport slave  (input push, pop, wdata, output rdata, full, empty);
endinterface

// File: rtl/ni_fifo.sv
// TX flit FIFO with wrap-bit pointers; head is presented combinationally on rdata.
module ni_fifo #(
   parameter int FLIT_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   ni_link_ctrl_if.slave  fif
);
   localparam int         AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q;
   logic [AW:0]       rptr_q;
   logic              wr_en;
   logic              rd_en;

   assign fif.full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign fif.empty = (wptr_q == rptr_q);
   assign fif.rdata = mem_q[rptr_q[AW-1:0]];

   // A write while full is allowed when the head slot is being freed in the same cycle.
   assign wr_en = fif.push && (!fif.full || fif.pop);
   assign rd_en = fif.pop && !fif.empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + PTR_ONE;
         if (rd_en) rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= fif.wdata;
   end

endmodule

// File: rtl/ni_link_ctrl.sv
// Network-interface link controller: buffers IP flits, runs a header handshake with the
// switch (retry on reject or timeout), then streams the packet; RX is a registered pass-through.
//
// state       | meaning
// ST_IDLE     | wait for a header at the FIFO head, discard anything else
// ST_REQ      | send head header to the switch (not popped)
// ST_WAIT_ACK | wait for a handshake reply, bounded by TIMEOUT cycles
// ST_SEND     | pop flits to the switch until the tail
module ni_link_ctrl
   import noc_pkg::*;
#(
   parameter int FLIT_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15,
   parameter int ACK_BIT = 21
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] ip_flit_in,
   input  logic              ip_valid,
   output logic              ip_ready,
   output logic [FLIT_W-1:0] sw_flit_out,
   output logic              sw_valid_out,
   input  logic [FLIT_W-1:0] sw_flit_in,
   input  logic              sw_valid_in,
   output logic [FLIT_W-1:0] ip_flit_out,
   output logic              ip_valid_out,
   output logic [1:0]        state,
   output logic              accept,
   output logic              timeout_err
);
   localparam int            CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WCNT_ONE  = CW'(1);

   link_state_e       state_q, state_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic              accept_q, accept_d;
   logic              tout_q, tout_d;
   logic [FLIT_W-1:0] sw_flit_q, sw_flit_d;
   logic              sw_valid_q, sw_valid_d;
   logic [FLIT_W-1:0] ip_flit_q, ip_flit_d;
   logic              ip_valid_q, ip_valid_d;

   logic [1:0]        head_type;
   logic              reply;
   logic              wait_last;

   ni_link_ctrl_if #(.FLIT_W(FLIT_W)) fif ();

   ni_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .fif   (fif)
   );

   assign ip_ready  = !fif.full;
   assign fif.push  = ip_valid && ip_ready;
   assign fif.wdata = ip_flit_in;

   assign head_type = fif.rdata[FLIT_W-1 -: 2];
   assign reply     = sw_valid_in && (sw_flit_in[FLIT_W-1 -: 2] == FT_HEAD);
   assign wait_last = (wcnt_q == WCNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (!fif.empty && head_type == FT_HEAD) state_d = ST_REQ;
         ST_REQ:      state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            // A reply on the last wait cycle beats the timeout.
            if (reply)          state_d = sw_flit_in[ACK_BIT] ? ST_SEND : ST_REQ;
            else if (wait_last) state_d = ST_REQ;
         end
         ST_SEND:     if (!fif.empty && head_type == FT_TAIL) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fif.pop    = 1'b0;
      sw_valid_d = 1'b0;
      sw_flit_d  = sw_flit_q;
      wcnt_d     = '0;
      accept_d   = accept_q;
      tout_d     = 1'b0;
      ip_valid_d = sw_valid_in;
      ip_flit_d  = sw_flit_in;
      case (state_q)
         ST_IDLE: begin
            if (!fif.empty && head_type != FT_HEAD) fif.pop = 1'b1;
         end
         ST_REQ: begin
            sw_valid_d = 1'b1;
            sw_flit_d  = fif.rdata;
         end
         ST_WAIT_ACK: begin
            ip_valid_d = 1'b0;
            ip_flit_d  = ip_flit_q;
            if (reply) begin
               accept_d = sw_flit_in[ACK_BIT];
            end else if (wait_last) begin
               tout_d   = 1'b1;
               accept_d = 1'b0;
            end else begin
               wcnt_d = wcnt_q + WCNT_ONE;
            end
         end
         ST_SEND: begin
            if (!fif.empty) begin
               fif.pop    = 1'b1;
               sw_valid_d = 1'b1;
               sw_flit_d  = fif.rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q     <= '0;
         accept_q   <= 1'b0;
         tout_q     <= 1'b0;
         sw_flit_q  <= '0;
         sw_valid_q <= 1'b0;
         ip_flit_q  <= '0;
         ip_valid_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         accept_q   <= accept_d;
         tout_q     <= tout_d;
         sw_flit_q  <= sw_flit_d;
         sw_valid_q <= sw_valid_d;
         ip_flit_q  <= ip_flit_d;
         ip_valid_q <= ip_valid_d;
      end
   end

   assign state        = state_q;
   assign accept       = accept_q;
   assign timeout_err  = tout_q;
   assign sw_flit_out  = sw_flit_q;
   assign sw_valid_out = sw_valid_q;
   assign ip_flit_out  = ip_flit_q;
   assign ip_valid_out = ip_valid_q;

endmodule

// File: tb/tb_ni_link_ctrl.sv
// Scoreboard bench for ni_link_ctrl: packets are planned as a list of handshake outcomes,
// the expected switch stream is queued up front and a monitor checks what the DUT emits.
module tb_ni_link_ctrl;
   localparam int FW = 32;
   localparam int TO = 15;
   localparam int K_REJECT = 0, K_ACCEPT = 1, K_TIMEOUT = 2;

   typedef struct { logic [31:0] data; bit is_data; int pkt; } exp_t;
   typedef struct { int kind; int delay; logic [31:0] rep; } plan_t;
   typedef struct { logic [31:0] data; int cyc; } rx_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] ip_flit_in = '0;
   logic          ip_valid = 1'b0;
   logic          ip_ready;
   logic [FW-1:0] sw_flit_out;
   logic          sw_valid_out;
   logic [FW-1:0] sw_flit_in = '0;
   logic          sw_valid_in = 1'b0;
   logic [FW-1:0] ip_flit_out;
   logic          ip_valid_out;
   logic [1:0]    state;
   logic          accept;
   logic          timeout_err;

   int checks = 0, errors = 0;
   int cyc = 0, pkt_id = -1, exp_timeouts = 0, seen_timeouts = 0;
   bit in_data = 0, expect_hdr = 0;

   exp_t        txq[$];
   plan_t       planq[$];
   rx_t         rxq[$];
   logic [31:0] push_q[$];
   logic [31:0] cur_pkt[$];
   plan_t       cur_plan[$];
   int          p0_cyc[$];

   ni_link_ctrl #(.FLIT_W(FW), .DEPTH(4), .TIMEOUT(TO), .ACK_BIT(21)) dut (
      .clk(clk), .rst_n(rst_n),
      .ip_flit_in(ip_flit_in), .ip_valid(ip_valid), .ip_ready(ip_ready),
      .sw_flit_out(sw_flit_out), .sw_valid_out(sw_valid_out),
      .sw_flit_in(sw_flit_in), .sw_valid_in(sw_valid_in),
      .ip_flit_out(ip_flit_out), .ip_valid_out(ip_valid_out),
      .state(state), .accept(accept), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk_rep(input bit acc);
      logic [31:0] r;
      r = $urandom;
      r[31:30] = 2'b11;
      r[21] = acc;
      return r;
   endfunction

   task automatic add_try(input int kind, input int delay, input logic [31:0] rep);
      plan_t p;
      p.kind = kind; p.delay = delay; p.rep = rep;
      cur_plan.push_back(p);
   endtask

   // Every attempt shows the header once; the accepted attempt is followed by the whole packet.
   task automatic commit();
      exp_t e;
      pkt_id++;
      foreach (cur_plan[i]) begin
         e.data = cur_pkt[0]; e.is_data = 0; e.pkt = pkt_id;
         txq.push_back(e);
         planq.push_back(cur_plan[i]);
         if (cur_plan[i].kind == K_TIMEOUT) exp_timeouts++;
      end
      foreach (cur_pkt[i]) begin
         e.data = cur_pkt[i]; e.is_data = 1; e.pkt = pkt_id;
         txq.push_back(e);
         push_q.push_back(cur_pkt[i]);
      end
      cur_pkt.delete();
      cur_plan.delete();
   endtask

   task automatic gen_pkt();
      logic [31:0] w;
      int nb, nr;
      if ($urandom_range(3) == 0) begin
         w = $urandom; w[31:30] = 2'($urandom_range(2));
         push_q.push_back(w);
      end
      w = $urandom; w[31:30] = 2'b11; cur_pkt.push_back(w);
      nb = $urandom_range(2);
      for (int i = 0; i < nb; i++) begin
         w = $urandom; w[31:30] = 2'($urandom_range(1)); cur_pkt.push_back(w);
      end
      w = $urandom; w[31:30] = 2'b10; cur_pkt.push_back(w);
      nr = $urandom_range(2);
      for (int i = 0; i < nr; i++) begin
         if ($urandom_range(3) == 0) add_try(K_TIMEOUT, 0, 32'h0);
         else add_try(K_REJECT, $urandom_range(TO - 1), mk_rep(1'b0));
      end
      add_try(K_ACCEPT, $urandom_range(TO - 1), mk_rep(1'b1));
      commit();
   endtask

   task automatic push_all(input bit gaps);
      int budget = 3000;
      while (push_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (gaps && $urandom_range(3) == 0) begin
            ip_valid = 1'b0;
         end else begin
            ip_flit_in = push_q[0];
            ip_valid = 1'b1;
            if (ip_ready) void'(push_q.pop_front());
         end
      end
      @(negedge clk);
      ip_valid = 1'b0;
      if (push_q.size() != 0) chk("push_timeout", push_q.size(), 0);
   endtask

   task automatic wait_drain();
      int b = 0;
      while ((txq.size() != 0 || planq.size() != 0) && b < 3000) begin
         @(negedge clk);
         b++;
      end
      if (b >= 3000) chk("drain_timeout", txq.size(), 0);
      repeat (3) @(negedge clk);
      chk("idle_state", state, 0);
   endtask

   // Monitor: switch stream, RX stream and timeout pulses.
   initial begin : monitor
      exp_t e;
      rx_t  r;
      bit   prev_to = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_to = 0;
         end else begin
            if (sw_valid_out) begin
               if (txq.size() == 0) chk("tx_unexpected", sw_flit_out, 32'h0);
               else begin
                  e = txq.pop_front();
                  chk("tx_flit", sw_flit_out, e.data);
                  if (e.is_data && e.pkt == 0) p0_cyc.push_back(cyc);
               end
            end
            if (ip_valid_out) begin
               if (rxq.size() == 0) chk("rx_unexpected", ip_flit_out, 32'h0);
               else begin
                  r = rxq.pop_front();
                  chk("rx_flit", ip_flit_out, r.data);
                  chk("rx_latency", cyc, r.cyc);
               end
            end
            if (timeout_err) begin
               seen_timeouts++;
               chk("timeout_clears_accept", accept, 0);
               if (prev_to) chk("timeout_pulse_width", 2, 1);
            end
            prev_to = timeout_err;
         end
      end
   end

   // Switch-side responder following the planned outcome of each handshake header.
   initial begin : responder
      plan_t p;
      int    n;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expect_hdr = 0;
         end else begin
            if (expect_hdr) begin
               chk("hdr_reissue", sw_valid_out, 1);
               expect_hdr = 0;
            end
            if (sw_valid_out && in_data) begin
               if (sw_flit_out[31:30] == 2'b10) in_data = 0;
            end else if (sw_valid_out && sw_flit_out[31:30] == 2'b11 && planq.size() > 0) begin
               p = planq.pop_front();
               if (p.kind == K_TIMEOUT) begin
                  n = 0;
                  while (!timeout_err && n < 40 && rst_n) begin
                     @(negedge clk);
                     n++;
                     if (n == 3) begin sw_flit_in = {2'b00, 30'($urandom)}; sw_valid_in = 1'b1; end
                     if (n == 4) sw_valid_in = 1'b0;
                  end
                  sw_valid_in = 1'b0;
                  chk("timeout_latency", n, TO);
                  expect_hdr = 1;
               end else begin
                  repeat (p.delay) @(negedge clk);
                  sw_flit_in = p.rep;
                  sw_valid_in = 1'b1;
                  @(negedge clk);
                  sw_valid_in = 1'b0;
                  chk("accept_latch", accept, p.rep[21]);
                  if (p.kind == K_ACCEPT) in_data = 1;
                  else expect_hdr = 1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int hits;
      int b;
      #12;
      chk("rst_state", state, 0);
      chk("rst_ip_ready", ip_ready, 1);
      chk("rst_sw_valid", sw_valid_out, 0);
      chk("rst_ip_valid", ip_valid_out, 0);
      chk("rst_accept", accept, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_sw_flit", sw_flit_out, 0);
      chk("rst_ip_flit", ip_flit_out, 0);
      @(negedge clk); rst_n = 1'b1;

      // RX pass-through while idle
      @(negedge clk);
      sw_flit_in = 32'h0000_00AA; sw_valid_in = 1'b1;
      rxq.push_back('{32'h0000_00AA, cyc + 1});
      @(negedge clk); sw_valid_in = 1'b0;
      repeat (2) @(negedge clk);

      // Accepted packet, reply two cycles after the header
      cur_pkt = '{32'hC000_0001, 32'h0000_0002, 32'h8000_0003};
      add_try(K_ACCEPT, 2, 32'hC020_0000);
      commit();
      push_all(1'b0);
      wait_drain();
      if (p0_cyc.size() == 3) begin
         chk("p0_consecutive_1", p0_cyc[1] - p0_cyc[0], 1);
         chk("p0_consecutive_2", p0_cyc[2] - p0_cyc[1], 1);
      end else chk("p0_data_count", p0_cyc.size(), 3);

      // Reject, then accept on the last cycle before timeout
      cur_pkt = '{32'hC000_0001, 32'h0000_0002, 32'h8000_0003};
      add_try(K_REJECT, 0, 32'hC000_0000);
      add_try(K_ACCEPT, TO - 1, mk_rep(1'b1));
      commit();
      push_all(1'b0);
      wait_drain();

      // Timeout while the FIFO fills, then push more while full
      cur_pkt = '{32'hC000_0005, 32'h0000_0006, 32'h4000_0007, 32'h8000_0008};
      add_try(K_TIMEOUT, 0, 32'h0);
      add_try(K_ACCEPT, 3, mk_rep(1'b1));
      commit();
      push_all(1'b0);
      chk("full_ip_ready", ip_ready, 0);
      gen_pkt();
      push_all(1'b0);
      wait_drain();

      // Randomized traffic
      for (int i = 0; i < 14; i++) gen_pkt();
      push_all(1'b1);
      wait_drain();

      // Random RX burst while idle (headers included, all forwarded)
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if ($urandom_range(1) == 1) begin
            sw_flit_in = $urandom; sw_valid_in = 1'b1;
            rxq.push_back('{sw_flit_in, cyc + 1});
         end else sw_valid_in = 1'b0;
      end
      @(negedge clk); sw_valid_in = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in SEND after the first data flit
      cur_pkt = '{32'hC000_0011, 32'h0000_0012, 32'h8000_0013};
      add_try(K_ACCEPT, 3, mk_rep(1'b1));
      commit();
      push_all(1'b0);
      hits = 0; b = 0;
      while (hits == 0 && b < 200) begin
         @(posedge clk); #1;
         b++;
         if (sw_valid_out && sw_flit_out == 32'hC000_0011 && in_data) hits = 1;
      end
      chk("send_reached", hits, 1);
      rst_n = 1'b0;
      #1;
      txq.delete(); planq.delete(); in_data = 0;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_sw_valid", sw_valid_out, 0);
      chk("mid_rst_sw_flit", sw_flit_out, 0);
      chk("mid_rst_ip_ready", ip_ready, 1);
      chk("mid_rst_accept", accept, 0);
      chk("mid_rst_ip_valid", ip_valid_out, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sw_valid_out) hits++;
      end
      chk("post_rst_no_tx", hits, 0);
      chk("post_rst_state", state, 0);
      chk("post_rst_ip_ready", ip_ready, 1);

      chk("timeouts_seen", seen_timeouts, exp_timeouts);
      chk("rx_drained", rxq.size(), 0);
      chk("plan_drained", planq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
